// File: rtl/dvi_timing_gen.sv
// Raster timing generator feeding the DVI TMDS encoders: de/hsync/vsync, coordinates, line/frame markers.
// Optional colour-bar test pattern when TEST_PATTERN_EN is defined; otherwise rgb is tied to zero.
module dvi_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic        pix_clk,
    input  logic        rst,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic [1:0]  control,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        line_start,
    output logic        frame_start,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // 13-bit bounds so a 4096 total or sync end still compares correctly against 12-bit counters
    localparam logic [12:0] H_ACT_E = 13'(H_ACTIVE);
    localparam logic [12:0] H_SS_E  = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] H_SE_E  = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] H_LAST  = 13'(H_TOTAL - 1);
    localparam logic [12:0] V_ACT_E = 13'(V_ACTIVE);
    localparam logic [12:0] V_SS_E  = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] V_SE_E  = 13'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [12:0] V_LAST  = 13'(V_TOTAL - 1);

    logic [11:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [12:0] h_e, v_e;
    logic        h_wrap, v_wrap;
    logic        de_d, hsync_d, vsync_d, ls_d, fs_d;
    logic        de_q, hsync_q, vsync_q, ls_q, fs_q;
    logic [11:0] x_q, y_q;

    assign h_e = {1'b0, h_cnt_q};
    assign v_e = {1'b0, v_cnt_q};

    always_comb begin
        h_wrap  = (h_e == H_LAST);
        v_wrap  = (v_e == V_LAST);
        h_cnt_d = h_wrap ? 12'd0 : h_cnt_q + 12'd1;
        v_cnt_d = v_cnt_q;
        if (h_wrap) v_cnt_d = v_wrap ? 12'd0 : v_cnt_q + 12'd1;
        de_d    = (h_e < H_ACT_E) && (v_e < V_ACT_E);
        hsync_d = ((h_e >= H_SS_E) && (h_e < H_SE_E)) ? HS_POL : !HS_POL;
        vsync_d = ((v_e >= V_SS_E) && (v_e < V_SE_E)) ? VS_POL : !VS_POL;
        ls_d    = (h_cnt_q == 12'd0);
        fs_d    = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
    end

    always_ff @(posedge pix_clk) begin
        if (rst) begin
            h_cnt_q <= 12'd0;
            v_cnt_q <= 12'd0;
            de_q    <= 1'b0;
            hsync_q <= !HS_POL;
            vsync_q <= !VS_POL;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
            x_q     <= 12'd0;
            y_q     <= 12'd0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            de_q    <= de_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
            x_q     <= h_cnt_q;
            y_q     <= v_cnt_q;
        end
    end

    assign de          = de_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign control     = {vsync_q, hsync_q};
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;

`ifdef TEST_PATTERN_EN
    logic [2:0]  bar;
    logic [23:0] rgb_d, rgb_q;

    always_comb begin
        bar = 3'd0;
        for (int k = 1; k < 8; k++)
            if (h_e >= 13'(k * H_ACTIVE / 8)) bar = 3'(k);
        case (bar)
            3'd0: rgb_d = 24'hFFFFFF;
            3'd1: rgb_d = 24'hFFFF00;
            3'd2: rgb_d = 24'h00FFFF;
            3'd3: rgb_d = 24'h00FF00;
            3'd4: rgb_d = 24'hFF00FF;
            3'd5: rgb_d = 24'hFF0000;
            3'd6: rgb_d = 24'h0000FF;
            default: rgb_d = 24'h000000;
        endcase
        if (!de_d) rgb_d = 24'h000000;
    end

    always_ff @(posedge pix_clk) begin
        if (rst) rgb_q <= 24'h000000;
        else     rgb_q <= rgb_d;
    end

    assign {red, green, blue} = rgb_q;
`else
    assign red   = 8'h00;
    assign green = 8'h00;
    assign blue  = 8'h00;
`endif
endmodule

// File: tb/tb_dvi_timing_gen.sv
// Directed bench: default 640x480 instance for reset/line/pattern/mid-frame reset,
// small 8x6 instance for frame-level timing and active-high sync polarity.
module tb_dvi_timing_gen;
    logic        pix_clk = 1'b0;
    logic        rst = 1'b1, rst_s = 1'b1;
    logic        de, hsync, vsync, ls, fs;
    logic [1:0]  control;
    logic [11:0] x, y;
    logic [7:0]  red, green, blue;
    logic        de_s, hs_s, vs_s, ls_s, fs_s;
    logic [1:0]  ctl_s;
    logic [11:0] x_s, y_s;
    logic [7:0]  r_s, g_s, b_s;

    int errs = 0, checks = 0;

    always #5 pix_clk = ~pix_clk;

    dvi_timing_gen dut (
        .pix_clk(pix_clk), .rst(rst), .de(de), .hsync(hsync), .vsync(vsync),
        .control(control), .x(x), .y(y), .line_start(ls), .frame_start(fs),
        .red(red), .green(green), .blue(blue)
    );

    dvi_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut_s (
        .pix_clk(pix_clk), .rst(rst_s), .de(de_s), .hsync(hs_s), .vsync(vs_s),
        .control(ctl_s), .x(x_s), .y(y_s), .line_start(ls_s), .frame_start(fs_s),
        .red(r_s), .green(g_s), .blue(b_s)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pix_clk);
        #1;
    endtask

    function automatic logic [23:0] bar_exp(input int xv);
`ifdef TEST_PATTERN_EN
        if (xv >= 640) return 24'h000000;
        case (xv / 80)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
`else
        return 24'h000000 | 24'(xv & 0);
`endif
    endfunction

    logic [23:0] rgb0 [0:799];
    logic        de0  [0:799];

    initial begin
        int de_cnt, hs_cnt, hs_first, last_ls, ls_gap, fs_cnt, seq_err;
        int hs_hi, vs_hi, de_s_cnt, last_fs, fs_gap, vs_fx, vs_fy, s_err;
        int tx [6];

        // reset state, default instance (active-low syncs idle high)
        repeat (5) tick();
        chk("rst_de", de, 0);
        chk("rst_hs", hsync, 1);
        chk("rst_vs", vsync, 1);
        chk("rst_ctl", control, 2'b11);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_ls", ls, 0);
        chk("rst_fs", fs, 0);
        chk("rst_rgb", {red, green, blue}, 0);

        rst = 1'b0;
        tick();
        chk("first_de", de, 1);
        chk("first_x", x, 0);
        chk("first_y", y, 0);
        chk("first_fs", fs, 1);
        chk("first_ls", ls, 1);

        // two full lines
        de_cnt = 0; hs_cnt = 0; hs_first = -1; last_ls = -1; ls_gap = 0; fs_cnt = 0; seq_err = 0;
        for (int i = 0; i < 1600; i++) begin
            if (int'(x) != i % 800 || int'(y) != i / 800) seq_err++;
            if (de) de_cnt++;
            if (!hsync) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(x);
            end
            if (ls) begin
                if (last_ls >= 0) ls_gap = i - last_ls;
                last_ls = i;
            end
            if (fs) fs_cnt++;
            if (i < 800) begin
                rgb0[i] = {red, green, blue};
                de0[i]  = de;
            end
            tick();
        end
        chk("line_xy_seq", seq_err, 0);
        chk("line_de_cnt", de_cnt, 1280);
        chk("line_hs_cnt", hs_cnt, 192);
        chk("line_hs_first", hs_first, 656);
        chk("line_ls_gap", ls_gap, 800);
        chk("line_fs_cnt", fs_cnt, 1);
        chk("line2_y", y, 2);

        tx = '{0, 79, 80, 560, 639, 700};
        foreach (tx[k]) chk($sformatf("rgb_x%0d", tx[k]), rgb0[tx[k]], bar_exp(tx[k]));
        chk("de_x700", de0[700], 0);
        chk("de_x639", de0[639], 1);

        // mid-frame reset
        repeat (300) tick();
        chk("mid_x", x, 300);
        chk("mid_y", y, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_de", de, 0);
        chk("mid_rst_x", x, 0);
        chk("mid_rst_hs", hsync, 1);
        tick();
        chk("mid_rel_x", x, 0);
        chk("mid_rel_y", y, 0);
        chk("mid_rel_fs", fs, 1);
        tick();
        chk("mid_next_x", x, 1);

        // small instance, active-high syncs idle low in reset
        chk("s_rst_hs", hs_s, 0);
        chk("s_rst_vs", vs_s, 0);
        chk("s_rst_de", de_s, 0);
        rst_s = 1'b0;
        tick();
        chk("s_first_fs", fs_s, 1);

        hs_hi = 0; vs_hi = 0; de_s_cnt = 0; last_fs = -1; fs_gap = 0; vs_fx = -1; vs_fy = -1; s_err = 0;
        for (int i = 0; i < 96; i++) begin
            if (int'(x_s) != i % 8 || int'(y_s) != (i / 8) % 6) s_err++;
            if (hs_s != (x_s == 5 || x_s == 6)) s_err++;
            if (de_s && y_s >= 3) s_err++;
            if (hs_s) hs_hi++;
            if (vs_s) begin
                vs_hi++;
                if (vs_fx < 0) begin
                    vs_fx = int'(x_s);
                    vs_fy = int'(y_s);
                end
            end
            if (de_s) de_s_cnt++;
            if (fs_s) begin
                if (last_fs >= 0) fs_gap = i - last_fs;
                last_fs = i;
            end
            tick();
        end
        chk("s_seq", s_err, 0);
        chk("s_hs_cnt", hs_hi, 24);
        chk("s_vs_cnt", vs_hi, 16);
        chk("s_vs_fx", vs_fx, 0);
        chk("s_vs_fy", vs_fy, 4);
        chk("s_de_cnt", de_s_cnt, 24);
        chk("s_fs_gap", fs_gap, 48);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
